// File: rtl/natalius_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : natalius_pkg
//  Brief   : Shared types and sizing constants for the Natalius loader slice.
//  Revision: 1.0  initial release
// ============================================================================
package natalius_pkg;

    localparam int IMEM_ADDR_W    = 11;
    localparam int INST_W         = 16;
    localparam int LOADER_TIMEOUT = 65535;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV_HI = 3'd1,
        RECV_LO = 3'd2,
        WRITE   = 3'd3,
        FINISH  = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/natalius_loader_if.sv
`default_nettype none
// ============================================================================
//  Module  : natalius_loader_if
//  Brief   : Host byte handshake plus SRAM port-0 write bus of the loader.
//  Revision: 1.0  initial release
// ============================================================================
interface natalius_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              csb0;
    logic              web0;
    logic [1:0]        wmask0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;

    // master: host/memory side; slave: the loader itself
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, csb0, web0, wmask0, addr0, din0
    );
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, csb0, web0, wmask0, addr0, din0
    );
endinterface
`default_nettype wire

// File: rtl/natalius_loader_timer.sv
`default_nettype none
// ============================================================================
//  Module  : natalius_loader_timer
//  Brief   : Clearable idle counter; expire flags the cycle that reaches LIMIT.
//  Revision: 1.0  initial release
// ============================================================================
module natalius_loader_timer #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 65535
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expire
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires on the idle cycle whose count step lands on LIMIT
    assign expire = en && (r_count == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/natalius_loader.sv
`default_nettype none
// ============================================================================
//  Module  : natalius_loader
//  Brief   : Packs host bytes into instruction words and writes SRAM port 0.
//  Revision: 1.0  initial release
// ============================================================================
module natalius_loader
    import natalius_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int DATA_W  = INST_W,
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load_start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W:0]   word_count,
    input  wire logic              cpu_release,
    natalius_loader_if.slave       bus,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             checksum
);
    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [ADDR_W:0]   r_remaining;
    logic [7:0]        r_checksum;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_hold;
    logic              w_in_recv;
    logic              w_xfer;
    logic              w_start;
    logic              w_expire;

    assign w_in_recv = (r_state == RECV_HI) || (r_state == RECV_LO);
    assign w_xfer    = w_in_recv && bus.byte_valid;
    assign w_start   = (r_state == IDLE) && load_start;

    natalius_loader_timer #(
        .CNT_W (16),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_xfer || w_start),
        .en     (w_in_recv && !bus.byte_valid),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next_state = (word_count == '0) ? FINISH : RECV_HI;
                end
            end
            RECV_HI: begin
                if (w_xfer)        w_next_state = RECV_LO;
                else if (w_expire) w_next_state = IDLE;
            end
            RECV_LO: begin
                if (w_xfer)        w_next_state = WRITE;
                else if (w_expire) w_next_state = IDLE;
            end
            WRITE:   w_next_state = (r_remaining == (ADDR_W+1)'(1)) ? FINISH : RECV_HI;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once
    always_comb begin
        bus.byte_ready = w_in_recv;
        bus.csb0       = (r_state != WRITE);
        bus.web0       = (r_state != WRITE);
        bus.wmask0     = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_din       <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_hold  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                        r_checksum  <= '0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cpu_hold  <= 1'b1;
                    end else if (cpu_release) begin
                        r_cpu_hold  <= 1'b0;
                    end
                end
                RECV_HI, RECV_LO: begin
                    if (w_xfer) begin
                        r_checksum <= r_checksum + bus.byte_data;
                        if (r_state == RECV_HI) r_din[DATA_W-1 -: 8] <= bus.byte_data;
                        else                    r_din[7:0]           <= bus.byte_data;
                    end else if (w_expire) begin
                        r_err  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                WRITE: begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - (ADDR_W+1)'(1);
                end
                FINISH: begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.addr0 = r_addr;
    assign bus.din0  = r_din;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_natalius_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_natalius_loader
//  Brief   : Scoreboard bench: expected SRAM writes queued, monitor pops them.
//  Revision: 1.0  initial release
// ============================================================================
module tb_natalius_loader;

    typedef struct {
        logic [10:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] word_count = '0;
    logic        cpu_release = 1'b0;
    logic        cpu_hold, busy, done, err;
    logic [7:0]  checksum;
    logic [7:0]  exp_sum;
    logic [15:0] mem [0:2047];
    logic        prev_wr = 1'b0;
    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    natalius_loader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    natalius_loader #(.ADDR_W(11), .DATA_W(16), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .cpu_release (cpu_release),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every port-0 write cycle must match the head of the queue
    always @(negedge clk) begin
        wr_t e;
        if (bus.csb0 === 1'b0) begin
            n_vec++;
            if (prev_wr) begin
                n_err++;
                $display("FAIL write_len: write lasted more than one cycle at addr 0x%0h", bus.addr0);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bus.addr0, bus.din0);
            end else begin
                e = exp_q.pop_front();
                if (bus.addr0 !== e.a || bus.din0 !== e.d || bus.web0 !== 1'b0 || bus.wmask0 !== 2'b11) begin
                    n_err++;
                    $display("FAIL write: got a=0x%0h d=0x%0h web0=%b wm=%b expected a=0x%0h d=0x%0h web0=0 wm=11",
                             bus.addr0, bus.din0, bus.web0, bus.wmask0, e.a, e.d);
                end
            end
            mem[bus.addr0] = bus.din0;
        end else if (rst_n && bus.web0 !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL web0_idle: got %b expected 1 while csb0 high", bus.web0);
        end
        prev_wr = (bus.csb0 === 1'b0);
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.byte_valid = 1'b0;
        exp_sum = exp_sum + b;
        chk("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic start_load(input logic [10:0] base, input logic [11:0] cnt);
        base_addr  = base;
        word_count = cnt;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        exp_sum    = 8'h00;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_done_clr", {31'd0, done}, 32'd0);
        chk("start_sum_clr", {24'd0, checksum}, 32'd0);
    endtask

    // Full load of up to two words; bytes given most-significant first
    task automatic do_load(input logic [10:0] base, input int cnt, input logic [31:0] bytes);
        int waited;
        start_load(base, 12'(cnt));
        for (int k = 0; k < cnt; k++)
            exp_q.push_back('{a: base + 11'(k), d: bytes[31-16*k -: 16]});
        for (int k = 0; k < 2*cnt; k++)
            send_byte(bytes[31-8*k -: 8]);
        waited = 0;
        while (busy === 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("load_busy_done", {31'd0, busy}, 32'd0);
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_err", {31'd0, err}, 32'd0);
        chk("load_hold", {31'd0, cpu_hold}, 32'd0);
        chk("load_checksum", {24'd0, checksum}, {24'd0, exp_sum});
        chk("load_writes_left", exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_csb0"}, {31'd0, bus.csb0}, 32'd1);
        chk({tag, "_web0"}, {31'd0, bus.web0}, 32'd1);
        chk({tag, "_wmask0"}, {30'd0, bus.wmask0}, 32'd3);
        chk({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        chk({tag, "_addr0"}, {21'd0, bus.addr0}, 32'd0);
        chk({tag, "_din0"}, {16'd0, bus.din0}, 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_sum"}, {24'd0, checksum}, 32'd0);
    endtask

    initial begin
        int i;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        exp_sum        = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // release without a load
        chk("pre_release_hold", {31'd0, cpu_hold}, 32'd1);
        cpu_release = 1'b1;
        @(posedge clk);
        #1;
        cpu_release = 1'b0;
        chk("release_hold", {31'd0, cpu_hold}, 32'd0);
        chk("release_done", {31'd0, done}, 32'd0);
        chk("release_busy", {31'd0, busy}, 32'd0);

        // basic two-word load, sum A5+5A+12+34 = 0x45 mod 256
        do_load(11'h010, 2, 32'hA55A_1234);
        chk("sum_basic", {24'd0, checksum}, 32'h45);
        chk("mem_010", {16'd0, mem[11'h010]}, 32'hA55A);
        chk("mem_011", {16'd0, mem[11'h011]}, 32'h1234);

        // address wrap at the top of memory
        do_load(11'h7FF, 2, 32'hDEAD_BEEF);
        chk("mem_7ff", {16'd0, mem[11'h7FF]}, 32'hDEAD);
        chk("mem_000", {16'd0, mem[11'h000]}, 32'hBEEF);

        // zero-length load: one busy cycle, no writes
        start_load(11'h050, 12'd0);
        @(posedge clk);
        #1;
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_hold", {31'd0, cpu_hold}, 32'd0);

        // timeout after three bytes; a second start during busy is ignored
        start_load(11'h020, 12'd2);
        exp_q.push_back('{a: 11'h020, d: 16'h0102});
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        for (i = 1; i <= 40; i++) begin
            if (i == 3) begin
                base_addr  = 11'h300;
                word_count = 12'd1;
                load_start = 1'b1;
            end
            @(posedge clk);
            #1;
            load_start = 1'b0;
            if (err === 1'b1) break;
        end
        chk("timeout_cycles", i, 32'd16);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_done", {31'd0, done}, 32'd0);
        chk("timeout_hold", {31'd0, cpu_hold}, 32'd1);
        chk("timeout_sum", {24'd0, checksum}, 32'h06);
        chk("timeout_writes_left", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("timeout_stays_idle", {31'd0, busy}, 32'd0);

        // reset asserted in the middle of a WRITE cycle
        start_load(11'h100, 12'd2);
        exp_q.push_back('{a: 11'h100, d: 16'h1122});
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        chk("pre_reset_in_write", {31'd0, bus.csb0}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_load(11'h100, 2, 32'h1122_3344);
        chk("mem_100", {16'd0, mem[11'h100]}, 32'h1122);
        chk("mem_101", {16'd0, mem[11'h101]}, 32'h3344);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
